// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor/negator: one full-adder slice per clock, LSB first.
// Define SERIAL_ADD_SUB_OVF_EN to add the io_ovf signed-overflow output.
module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_start,
    input  logic [1:0]       io_op,
    input  logic [WIDTH-1:0] io_a,
    input  logic [WIDTH-1:0] io_b,
    output logic             io_busy,
    output logic             io_done,
    output logic [WIDTH-1:0] io_result,
    output logic             io_cout,
    output logic             io_zero,
    output logic             io_neg
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             io_ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NEG = 2'b10,
        OP_RSV = 2'b11
    } op_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic             carry_q;
    logic [CW-1:0]    count_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             zero_q;
    logic             neg_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic             sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] sa_load_d;
    logic [WIDTH-1:0] sb_load_d;
    logic             carry_load_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sa_load_d    = io_a;
        sb_load_d    = io_b;
        carry_load_d = 1'b0;
        unique case (op_t'(io_op))
            OP_SUB: begin
                sb_load_d    = ~io_b;
                carry_load_d = 1'b1;
            end
            OP_NEG: begin
                sa_load_d    = '0;
                sb_load_d    = ~io_b;
                carry_load_d = 1'b1;
            end
            OP_ADD, OP_RSV: begin
                sa_load_d    = io_a;
                sb_load_d    = io_b;
                carry_load_d = 1'b0;
            end
        endcase
    end

    // The single full-adder slice; subtraction is a + ~b + 1 via the preset carry.
    always_comb begin
        sum_d   = sa_q[0] ^ sb_q[0] ^ carry_q;
        carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        sr_d    = {sum_d, sr_q[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shift registers are reset too, so an aborted operation leaves no residue.
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sr_q     <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (io_start) begin
                        sa_q    <= sa_load_d;
                        sb_q    <= sb_load_d;
                        carry_q <= carry_load_d;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sa_q    <= sa_q >> 1;
                    sb_q    <= sb_q >> 1;
                    sr_q    <= sr_d;
                    carry_q <= carry_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_BIT) begin
                        result_q <= sr_d;
                        cout_q   <= carry_d;
                        zero_q   <= (sr_d == '0);
                        neg_q    <= sr_d[WIDTH-1];
`ifdef SERIAL_ADD_SUB_OVF_EN
                        // carry_q here is the carry into the MSB slot.
                        ovf_q    <= carry_q ^ carry_d;
`endif
                        count_q  <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io_busy   = busy_q;
    assign io_done   = done_q;
    assign io_result = result_q;
    assign io_cout   = cout_q;
    assign io_zero   = zero_q;
    assign io_neg    = neg_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
    assign io_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed plan cases plus random ops against an arithmetic model.
// Exercises io_ovf when SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

    localparam int W  = 32;
    localparam int W4 = 4;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0;
    logic        start4  = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;

    logic          busy32, done32, cout32, zero32, neg32;
    logic [W-1:0]  res32;
    logic          busy4, done4, cout4, zero4, neg4;
    logic [W4-1:0] res4;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic          ovf32, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_add_sub #(.WIDTH(W)) dut32 (
        .clock(clock), .reset_n(reset_n), .io_start(start32), .io_op(op),
        .io_a(a), .io_b(b), .io_busy(busy32), .io_done(done32), .io_result(res32),
        .io_cout(cout32), .io_zero(zero32), .io_neg(neg32)
`ifdef SERIAL_ADD_SUB_OVF_EN
        , .io_ovf(ovf32)
`endif
    );

    serial_add_sub #(.WIDTH(W4)) dut4 (
        .clock(clock), .reset_n(reset_n), .io_start(start4), .io_op(op),
        .io_a(a[W4-1:0]), .io_b(b[W4-1:0]), .io_busy(busy4), .io_done(done4), .io_result(res4),
        .io_cout(cout4), .io_zero(zero4), .io_neg(neg4)
`ifdef SERIAL_ADD_SUB_OVF_EN
        , .io_ovf(ovf4)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic; cout is "no borrow" for subtract/negate.
    task automatic model(input int width, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] r, output logic c, output logic ov);
        logic [63:0] mask, xa, yb, full;
        mask = (64'd1 << width) - 64'd1;
        xa   = x & mask;
        yb   = y & mask;
        case (o)
            2'b01: begin
                full = xa - yb;
                r    = full & mask;
                c    = (xa >= yb);
                ov   = (xa[width-1] != yb[width-1]) && (r[width-1] != xa[width-1]);
            end
            2'b10: begin
                r  = (64'd0 - yb) & mask;
                c  = (yb == 64'd0);
                ov = yb[width-1] && r[width-1];
            end
            default: begin
                full = xa + yb;
                r    = full & mask;
                c    = full[width];
                ov   = (xa[width-1] == yb[width-1]) && (r[width-1] != xa[width-1]);
            end
        endcase
    endtask

    // Starts one op on the 32-bit DUT in the current cycle and checks timing and results.
    // glitch: pulse io_start mid-RUN with other operands. chain: stay in the done cycle on return.
    task automatic run32(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit glitch, input bit chain);
        logic [63:0] er;
        logic        ec, eo;
        logic [31:0] prev;
        int          edges, busy_n;
        bit          stable;
        model(W, o, {32'd0, x}, {32'd0, y}, er, ec, eo);
        prev    = res32;
        op      = o;
        a       = x;
        b       = y;
        start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        edges   = 0;
        busy_n  = 0;
        stable  = 1'b1;
        while (!done32 && edges <= W + 3) begin
            if (busy32) busy_n++;
            if (res32 !== prev) stable = 1'b0;
            if (glitch && edges == 5) begin
                start32 = 1'b1;
                op      = ~o;
                a       = ~x;
                b       = x ^ y;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clock); #1;
            edges++;
        end
        start32 = 1'b0;
        check({tag, " done_edge"}, edges, W);
        check({tag, " busy_cycles"}, busy_n, W);
        check({tag, " result_held"}, stable, 1'b1);
        check({tag, " busy_at_done"}, busy32, 1'b0);
        check({tag, " result"}, res32, er[31:0]);
        check({tag, " cout"}, cout32, ec);
        check({tag, " zero"}, zero32, er[31:0] == 32'd0);
        check({tag, " neg"}, neg32, er[31]);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check({tag, " ovf"}, ovf32, eo);
`endif
        if (!chain) begin
            @(posedge clock); #1;
            check({tag, " done_pulse"}, done32, 1'b0);
            check({tag, " idle_busy"}, busy32, 1'b0);
            check({tag, " result_after"}, res32, er[31:0]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;
        logic [31:0] picks [4];
        logic [31:0] x, y;
        picks[0] = 32'h0000_0000;
        picks[1] = 32'hFFFF_FFFF;
        picks[2] = 32'h8000_0000;
        picks[3] = 32'h7FFF_FFFF;

        #3;
        check("reset busy", busy32, 1'b0);
        check("reset done", done32, 1'b0);
        check("reset result", res32, 32'd0);
        check("reset cout", cout32, 1'b0);
        check("reset zero", zero32, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run32("add 5+3", 2'b00, 32'd5, 32'd3, 1'b0, 1'b0);
        run32("sub 3-5", 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
        run32("sub 5-5", 2'b01, 32'd5, 32'd5, 1'b0, 1'b0);
        run32("neg 7", 2'b10, 32'h1234_5678, 32'd7, 1'b0, 1'b0);
        run32("rsv 1+1", 2'b11, 32'd1, 32'd1, 1'b0, 1'b0);
        run32("ovf add", 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        run32("ovf sub", 2'b01, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        run32("neg min", 2'b10, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
        run32("neg 0", 2'b10, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
        run32("midrun start", 2'b00, 32'd100, 32'd23, 1'b1, 1'b0);

        run32("b2b first", 2'b00, 32'd10, 32'd20, 1'b0, 1'b1);
        run32("b2b second", 2'b01, 32'd10, 32'd20, 1'b0, 1'b0);

        op     = 2'b00;
        a      = 32'hF;
        b      = 32'h1;
        start4 = 1'b1;
        @(posedge clock); #1;
        start4 = 1'b0;
        edges  = 0;
        while (!done4 && edges <= W4 + 3) begin
            @(posedge clock); #1;
            edges++;
        end
        check("w4 done_edge", edges, W4);
        check("w4 result", res4, 4'h0);
        check("w4 cout", cout4, 1'b1);
        check("w4 zero", zero4, 1'b1);
        check("w4 neg", neg4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 3) == 0) x = picks[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) y = picks[$urandom_range(0, 3)];
            run32($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), x, y, 1'b0, 1'b0);
        end

        run32("pre-reset sub", 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
        op      = 2'b00;
        a       = 32'd1;
        b       = 32'd2;
        start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        check("pre-reset busy", busy32, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async busy", busy32, 1'b0);
        check("async done", done32, 1'b0);
        check("async result", res32, 32'd0);
        check("async cout", cout32, 1'b0);
        check("async zero", zero32, 1'b0);
        check("async neg", neg32, 1'b0);
`ifdef SERIAL_ADD_SUB_OVF_EN
        check("async ovf", ovf32, 1'b0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("post-reset idle", busy32, 1'b0);
        check("post-reset done", done32, 1'b0);
        run32("post-reset 1+1", 2'b00, 32'd1, 32'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
